// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - four-requester message-locked round-robin arbiter feeding a UART TX FIFO
module uart_tx_arb #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_push,
    input  logic        tx_full,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  err_owner,
    input  logic        err_clr
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [1:0]  err_owner_q, err_owner_d;

    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;

    logic        owner_valid;
    logic        owner_last;
    logic [7:0]  owner_data;
    logic [3:0]  owner_oh;
    logic        timeout_hit;
    logic        ready_own;
    logic        xfer;

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_data  = req_data[{owner_q, 3'b000} +: 8];
    assign owner_oh    = 4'b0001 << owner_q;

    // The timeout cycle itself blocks the owner so a force-release never carries a byte with it.
    assign timeout_hit = (state_q == LOCKED) && (TIMEOUT != 16'd0) && (idle_cnt_q >= TIMEOUT);
    assign ready_own   = (state_q == LOCKED) && !tx_full && !timeout_hit;
    assign xfer        = ready_own && owner_valid;

    // Round-robin search: first valid requester starting at rr_ptr and wrapping modulo 4.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Datapath outputs: everything is gated by LOCKED so IDLE and reset present all zeros.
    always_comb begin
        req_ready   = 4'b0000;
        grant       = 4'b0000;
        busy        = 1'b0;
        tx_data     = 8'h00;
        tx_push     = 1'b0;
        timeout_err = timeout_err_q;
        err_owner   = err_owner_q;
        if (state_q == LOCKED) begin
            grant   = owner_oh;
            busy    = 1'b1;
            tx_data = owner_data;
            tx_push = xfer;
            if (ready_own) begin
                req_ready = owner_oh;
            end
        end
    end

    // Next-state: arbitration in IDLE, message lock with idle-timeout supervision in LOCKED.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = timeout_err_q;
        err_owner_d   = err_owner_q;

        if (state_q == IDLE) begin
            if (pick_found) begin
                state_d    = LOCKED;
                owner_d    = pick_idx;
                idle_cnt_d = 16'd0;
            end
        end else begin
            if (timeout_hit) begin
                state_d    = IDLE;
                rr_ptr_d   = owner_q + 2'd1;
                idle_cnt_d = 16'd0;
            end else if (xfer) begin
                idle_cnt_d = 16'd0;
                if (owner_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + 2'd1;
                end
            end else if (!owner_valid) begin
                if (idle_cnt_q != 16'hFFFF) begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
        end

        // A timeout in the same cycle as err_clr keeps the flag set and records the new owner.
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
            err_owner_d   = owner_q;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= 2'd0;
            rr_ptr_q      <= 2'd0;
            idle_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
            err_owner_q   <= 2'd0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
            err_owner_q   <= err_owner_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scenario bench for uart_tx_arb with a push-order scoreboard
module tb_uart_tx_arb;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_push;
    logic        tx_full;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_err;
    logic [1:0]  err_owner;
    logic        err_clr;

    int n_checks;
    int n_fail;

    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    logic [8:0] rq2[$];
    logic [8:0] rq3[$];
    logic [9:0] sb[$];
    logic [3:0] fire;
    logic [9:0] sb_e;

    uart_tx_arb #(.TIMEOUT(16'd4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_push     (tx_push),
        .tx_full     (tx_full),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_owner   (err_owner),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    // Scoreboard: every push must match the next expected {owner, byte}.
    always @(negedge clk) begin
        fire = req_valid & req_ready;
        if (reset_n && tx_push) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_push: unexpected push grant=%b data=%h, required no push", grant, tx_data);
            end else begin
                sb_e = sb.pop_front();
                if (grant !== oh(int'(sb_e[9:8])) || tx_data !== sb_e[7:0]) begin
                    n_fail++;
                    $display("FAIL sb_push: got grant=%b data=%h, required grant=%b data=%h",
                             grant, tx_data, oh(int'(sb_e[9:8])), sb_e[7:0]);
                end
            end
        end
    end

    task automatic load(input int r, input logic [7:0] d, input logic last);
        case (r)
            0: rq0.push_back({last, d});
            1: rq1.push_back({last, d});
            2: rq2.push_back({last, d});
            default: rq3.push_back({last, d});
        endcase
    endtask

    task automatic expect_push(input int r, input logic [7:0] d);
        sb.push_back({2'(r), d});
    endtask

    task automatic flush();
        rq0.delete(); rq1.delete(); rq2.delete(); rq3.delete();
    endtask

    task automatic drive();
        req_valid = 4'b0; req_data = 32'h0; req_last = 4'b0;
        if (rq0.size() != 0) begin req_valid[0] = 1'b1; req_data[7:0]   = rq0[0][7:0]; req_last[0] = rq0[0][8]; end
        if (rq1.size() != 0) begin req_valid[1] = 1'b1; req_data[15:8]  = rq1[0][7:0]; req_last[1] = rq1[0][8]; end
        if (rq2.size() != 0) begin req_valid[2] = 1'b1; req_data[23:16] = rq2[0][7:0]; req_last[2] = rq2[0][8]; end
        if (rq3.size() != 0) begin req_valid[3] = 1'b1; req_data[31:24] = rq3[0][7:0]; req_last[3] = rq3[0][8]; end
    endtask

    // One clock: retire accepted bytes, present the next ones, let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (fire[0] && rq0.size() != 0) void'(rq0.pop_front());
        if (fire[1] && rq1.size() != 0) void'(rq1.pop_front());
        if (fire[2] && rq2.size() != 0) void'(rq2.pop_front());
        if (fire[3] && rq3.size() != 0) void'(rq3.pop_front());
        drive();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load(1, 8'h99, 1'b1);
        tick(); tick();
        n_checks++;
        if (req_ready !== 4'b0 || tx_push !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_datapath: ready=%b push=%b data=%h, required 0000 0 00", req_ready, tx_push, tx_data);
        end
        n_checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || err_owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status: grant=%b busy=%b terr=%b eown=%0d, required 0000 0 0 0",
                     grant, busy, timeout_err, err_owner);
        end
        flush();
        drive();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single_message();
        load(2, 8'h41, 1'b0); load(2, 8'h42, 1'b0); load(2, 8'h43, 1'b1);
        expect_push(2, 8'h41); expect_push(2, 8'h42); expect_push(2, 8'h43);
        tick();
        n_checks++;
        if (grant !== 4'b0 || tx_push !== 1'b0) begin
            n_fail++;
            $display("FAIL single_arb_cycle: grant=%b push=%b, required 0000 0", grant, tx_push);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (grant !== 4'b0100 || tx_push !== 1'b1) begin
                n_fail++;
                $display("FAIL single_byte%0d: grant=%b push=%b, required 0100 1", k, grant, tx_push);
            end
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd3) begin
            n_fail++;
            $display("FAIL single_release: busy=%b rr_ptr=%0d, required 0 3", busy, dut.rr_ptr_q);
        end
    endtask

    task automatic test_round_robin();
        int ord[5];
        ord = '{0, 1, 2, 3, 0};
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        load(0, 8'hC0, 1'b1); load(0, 8'hC4, 1'b1);
        load(1, 8'hC1, 1'b1); load(2, 8'hC2, 1'b1); load(3, 8'hC3, 1'b1);
        expect_push(0, 8'hC0); expect_push(1, 8'hC1); expect_push(2, 8'hC2);
        expect_push(3, 8'hC3); expect_push(0, 8'hC4);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || tx_push !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: busy=%b push=%b, required 0 0", k, busy, tx_push);
            end
            tick();
            n_checks++;
            if (grant !== oh(ord[k]) || tx_push !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: grant=%b push=%b, required %b 1", k, grant, tx_push, oh(ord[k]));
            end
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        tx_full = 1'b1;
        load(1, 8'h55, 1'b1);
        expect_push(1, 8'h55);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (req_ready[1] !== 1'b0 || tx_push !== 1'b0 || busy !== 1'b1 || grant !== 4'b0010) begin
                n_fail++;
                $display("FAIL stall%0d: ready1=%b push=%b busy=%b grant=%b, required 0 0 1 0010",
                         k, req_ready[1], tx_push, busy, grant);
            end
        end
        tick();
        tx_full = 1'b0;
        #1;
        n_checks++;
        if (req_ready[1] !== 1'b1 || tx_push !== 1'b1 || tx_data !== 8'h55) begin
            n_fail++;
            $display("FAIL stall_release: ready1=%b push=%b data=%h, required 1 1 55", req_ready[1], tx_push, tx_data);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: busy=%b terr=%b, required 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_timeout();
        load(2, 8'h77, 1'b0);
        load(3, 8'h33, 1'b1);
        load(0, 8'h10, 1'b1);
        expect_push(2, 8'h77); expect_push(3, 8'h33); expect_push(0, 8'h10);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (busy !== 1'b1 || tx_push !== 1'b0 || grant !== 4'b0100) begin
                n_fail++;
                $display("FAIL to_wait%0d: busy=%b push=%b grant=%b, required 1 0 0100", k, busy, tx_push, grant);
            end
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || err_owner !== 2'd2) begin
            n_fail++;
            $display("FAIL to_fire: busy=%b terr=%b eown=%0d, required 0 1 2", busy, timeout_err, err_owner);
        end
        tick();
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL to_next_owner: grant=%b, required 1000", grant);
        end
        tick();
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL to_wrap_owner: grant=%b, required 0001", grant);
        end
        tick();
    endtask

    task automatic test_err_clr();
        load(0, 8'h20, 1'b0);
        expect_push(0, 8'h20);
        tick();
        tick();
        for (int k = 0; k < 4; k++) tick();
        tick();
        err_clr = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1 || tx_push !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_timeout_cycle: busy=%b push=%b, required 1 0", busy, tx_push);
        end
        tick();
        err_clr = 1'b0;
        #1;
        n_checks++;
        if (timeout_err !== 1'b1 || err_owner !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_collision: terr=%b eown=%0d busy=%b, required 1 0 0", timeout_err, err_owner, busy);
        end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_lone: terr=%b, required 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid_message();
        load(3, 8'hA0, 1'b0); load(3, 8'hA1, 1'b0); load(3, 8'hA2, 1'b0); load(3, 8'hA3, 1'b1);
        expect_push(3, 8'hA0); expect_push(3, 8'hA1);
        tick();
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (tx_push !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_mid: push=%b grant=%b busy=%b ready=%b, required 0 0000 0 0000",
                     tx_push, grant, busy, req_ready);
        end
        flush();
        load(0, 8'hB0, 1'b1);
        load(2, 8'hB2, 1'b1);
        expect_push(0, 8'hB0); expect_push(2, 8'hB2);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (grant !== 4'b0 || tx_push !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_idle: grant=%b push=%b, required 0000 0", grant, tx_push);
        end
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_restart_owner: grant=%b, required 0001", grant);
        end
        tick();
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_second_owner: grant=%b, required 0100", grant);
        end
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        fire      = 4'b0;
        reset_n   = 1'b0;
        tx_full   = 1'b0;
        err_clr   = 1'b0;
        req_valid = 4'b0;
        req_data  = 32'h0;
        req_last  = 4'b0;

        test_reset();
        test_single_message();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_err_clr();
        test_reset_mid_message();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d pushes outstanding, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: TIMEOUT, default 16'd1000, idle-cycle limit while a message is locked; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  4  per-requester byte valid; bit i is requester i.
REQ-005 req_data  input  32  per-requester byte; requester i on [8i+7:8i].
REQ-006 req_last  input  4  per-requester last-byte-of-message flag, qualified by req_valid.
REQ-007 req_ready  output  4  per-requester accept; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 tx_data  output  8  byte to the UART transmitter FIFO.
REQ-009 tx_push  output  1  push strobe to the UART transmitter FIFO.
REQ-010 tx_full  input  1  UART transmitter FIFO full.
REQ-011 grant  output  4  one-hot current owner; all zero when unlocked.
REQ-012 busy  output  1  high while a message is locked.
REQ-013 timeout_err  output  1  sticky flag: a locked message was force-released.
REQ-014 err_owner  output  2  index of the requester that caused the last timeout.
REQ-015 err_clr  input  1  single-cycle clear of timeout_err.

Function
REQ-016 FSM SHALL have two states: IDLE and LOCKED.
REQ-017 In IDLE with any req_valid high, the owner SHALL be the first valid requester searched round-robin from rr_ptr upward, modulo 4; next state LOCKED.
REQ-018 In IDLE with no req_valid, the FSM SHALL stay in IDLE; req_ready and grant SHALL be all zero in IDLE.
REQ-019 Arbitration latency SHALL be exactly 1 cycle: no byte transfers in the IDLE cycle in which the owner is chosen.
REQ-020 In LOCKED, req_ready[owner] SHALL be ~tx_full, combinationally; all other req_ready bits SHALL be 0.
REQ-021 tx_push SHALL equal req_valid[owner] & req_ready[owner], combinationally, in the same cycle as the transfer.
REQ-022 tx_data SHALL equal req_data of the owner whenever LOCKED; it SHALL be 8'h00 in IDLE.
REQ-023 A transfer with req_last[owner] high SHALL return the FSM to IDLE next cycle and set rr_ptr to (owner+1) mod 4.
REQ-024 Requests from non-owners SHALL never interleave within a locked message.
REQ-025 Idle counter, 16 bits: SHALL clear on entering LOCKED and on every transfer.
REQ-026 The idle counter SHALL increment only in LOCKED cycles with req_valid[owner] low.
REQ-027 Cycles stalled by tx_full with req_valid[owner] high SHALL hold the counter.
REQ-028 When TIMEOUT is nonzero and the counter reaches TIMEOUT, the FSM SHALL go to IDLE next cycle with rr_ptr=(owner+1) mod 4.
REQ-029 On that timeout event, timeout_err SHALL set and err_owner SHALL capture the owner; no transfer occurs in the timeout cycle.
REQ-030 err_clr SHALL clear timeout_err next cycle; a simultaneous timeout event SHALL win (flag stays 1, err_owner updated).
REQ-031 busy SHALL be high exactly when the FSM is in LOCKED; grant SHALL be the one-hot owner when LOCKED.
REQ-032 The counter SHALL saturate and never wrap.

Reset
REQ-033 On reset_n low, asynchronously: FSM=IDLE, rr_ptr=0, owner=0, idle counter=0, timeout_err=0, err_owner=0.
REQ-034 During reset, outputs SHALL be req_ready=0, tx_push=0, tx_data=8'h00, grant=0, busy=0.
REQ-035 Reset mid-message SHALL abandon the message without emitting further tx_push; after release, arbitration SHALL restart from requester 0.

Verification
REQ-036 Reset release, req_valid=4'b0100, 3-byte message 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> grant=4'b0100 one cycle later; tx_push on 3 consecutive cycles with tx_data 41,42,43; busy low next cycle; rr_ptr=3.
REQ-037 All four requesters hold 1-byte messages continuously -> grant order 0,1,2,3,0; every message takes 2 cycles.
REQ-038 Requester 1 is locked and sends byte 0x55 while tx_full=1 for 5 cycles -> req_ready[1]=0 and no tx_push for 5 cycles; 0x55 is pushed in the cycle tx_full drops; no timeout.
REQ-039 TIMEOUT=4; requester 2 sends one non-last byte, then drops req_valid -> after 4 idle cycles: busy=0, timeout_err=1, err_owner=2; requester 3 is granted next.
REQ-040 err_clr pulses in the same cycle as a new timeout by requester 0 -> timeout_err stays 1 and err_owner=0; a later lone err_clr -> timeout_err=0.
REQ-041 Assert reset_n low mid-message (after 2 of 4 bytes) -> tx_push=0 and grant=0 immediately; after release, requester 0 wins when requesters 0 and 2 are both valid.
